// File: rtl/display_value_counter_if.sv
// Board-side signals of the 0..19 display value counter: raw keys and
// processor load in, registered count and status pulses out.
interface display_value_counter_if;
    logic       key_up;
    logic       key_down;
    logic       load;
    logic [4:0] load_val;
    logic [4:0] value;
    logic       wrap;
    logic       clamped;

    modport master (
        output key_up, key_down, load, load_val,
        input  value, wrap, clamped
    );

    modport slave (
        input  key_up, key_down, load, load_val,
        output value, wrap, clamped
    );
endinterface

// File: rtl/display_value_counter.sv
// Push-button up/down counter for the two-digit seven-segment path:
// synchronizes and debounces both keys, turns each debounced press into a
// single step, and keeps value in 0..MAX_VALUE with wrap and load clamping.
module display_value_counter #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned MAX_VALUE       = 19
) (
    input  logic                     clk,
    input  logic                     reset,
    display_value_counter_if.slave   bus
);

    localparam int unsigned   CW       = $clog2(DEBOUNCE_CYCLES + 1);
    // Last count before the stable level flips (D-th consecutive mismatch).
    localparam logic [CW-1:0] DEB_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [4:0]    MAX_V    = 5'(MAX_VALUE);

    // Bit 0 is the up key, bit 1 the down key throughout.
    logic [1:0]         raw_keys;
    logic [1:0]         meta_q, meta_d;
    logic [1:0]         sync_q, sync_d;
    logic [1:0]         stable_q, stable_d;
    logic [1:0]         stable_prev_q, stable_prev_d;
    logic [1:0]         ev_q, ev_d;
    logic [1:0][CW-1:0] cnt_q, cnt_d;
    logic [4:0]         value_q, value_d;
    logic               wrap_q, wrap_d;
    logic               clamped_q, clamped_d;

    assign raw_keys = {bus.key_down, bus.key_up};

    // Two-flop synchronizer stages per key.
    always_comb begin
        meta_d = raw_keys;
        sync_d = meta_q;
    end

    // Debounce: flip the stable level after DEBOUNCE_CYCLES consecutive mismatches.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = '0;
        for (int unsigned i = 0; i < 2; i++) begin
            if (sync_q[i] != stable_q[i]) begin
                if (cnt_q[i] == DEB_LAST) begin
                    stable_d[i] = ~stable_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    // Press detector: one-cycle event on a debounced 0->1 transition only.
    always_comb begin
        stable_prev_d = stable_q;
        ev_d          = stable_q & ~stable_prev_q;
    end

    // Value update: load beats key events, simultaneous events cancel.
    always_comb begin
        value_d   = value_q;
        wrap_d    = 1'b0;
        clamped_d = 1'b0;
        if (bus.load) begin
            if (bus.load_val > MAX_V) begin
                value_d   = MAX_V;
                clamped_d = 1'b1;
            end else begin
                value_d = bus.load_val;
            end
        end else if (ev_q == 2'b11) begin
            value_d = value_q;
        end else if (ev_q[0]) begin
            if (value_q >= MAX_V) begin
                value_d = '0;
                wrap_d  = 1'b1;
            end else begin
                value_d = value_q + 5'd1;
            end
        end else if (ev_q[1]) begin
            if (value_q == '0) begin
                value_d = MAX_V;
                wrap_d  = 1'b1;
            end else begin
                value_d = value_q - 5'd1;
            end
        end
    end

    // State register with synchronous reset; reset drops any pending debounce.
    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q        <= '0;
            sync_q        <= '0;
            stable_q      <= '0;
            stable_prev_q <= '0;
            ev_q          <= '0;
            cnt_q         <= '0;
            value_q       <= '0;
            wrap_q        <= 1'b0;
            clamped_q     <= 1'b0;
        end else begin
            meta_q        <= meta_d;
            sync_q        <= sync_d;
            stable_q      <= stable_d;
            stable_prev_q <= stable_prev_d;
            ev_q          <= ev_d;
            cnt_q         <= cnt_d;
            value_q       <= value_d;
            wrap_q        <= wrap_d;
            clamped_q     <= clamped_d;
        end
    end

    assign bus.value   = value_q;
    assign bus.wrap    = wrap_q;
    assign bus.clamped = clamped_q;

endmodule

// File: tb/tb_display_value_counter.sv
// Scoreboard bench for display_value_counter: a cycle-level reference model
// predicts value/wrap/clamped after every clock edge; a monitor compares.
module tb_display_value_counter;

    localparam int unsigned D    = 4;
    localparam int          MAXV = 19;
    localparam int          HL   = 16;

    logic clk = 1'b0;
    logic reset;

    display_value_counter_if bus ();

    display_value_counter #(
        .DEBOUNCE_CYCLES(D),
        .MAX_VALUE(MAXV)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int value;
        int wrap;
        int clamped;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    function automatic void check(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    // Reference model: key i is debounced by looking at a window of the last
    // D synchronized samples (2-cycle delayed raw input); the level flips when
    // all of them disagree with it. A rise becomes an event one edge later and
    // the event steps the value one edge after that.
    int n = 0;
    int m_val = 0;
    int m1[2], m2[2], lvl[2], rose_last[2], ev[2], start[2];
    int hist[2][HL];

    function automatic void model_edge(int rst, int ku, int kd, int ld, int lv);
        int raw[2];
        int s, all_diff, rose, w, c;
        exp_t e;
        raw[0] = ku;
        raw[1] = kd;
        n++;
        w = 0;
        c = 0;
        if (rst != 0) begin
            m_val = 0;
            for (int i = 0; i < 2; i++) begin
                m1[i] = 0; m2[i] = 0; lvl[i] = 0;
                rose_last[i] = 0; ev[i] = 0; start[i] = n + 1;
            end
        end else begin
            if (ld != 0) begin
                if (lv > MAXV) begin
                    m_val = MAXV;
                    c = 1;
                end else begin
                    m_val = lv;
                end
            end else if (ev[0] != 0 && ev[1] != 0) begin
                m_val = m_val;
            end else if (ev[0] != 0) begin
                m_val = (m_val + 1) % (MAXV + 1);
                w = (m_val == 0) ? 1 : 0;
            end else if (ev[1] != 0) begin
                w = (m_val == 0) ? 1 : 0;
                m_val = (m_val == 0) ? MAXV : m_val - 1;
            end
            for (int i = 0; i < 2; i++) begin
                ev[i] = rose_last[i];
                s = m2[i];
                hist[i][n % HL] = s;
                rose = 0;
                if (n - start[i] + 1 >= int'(D)) begin
                    all_diff = 1;
                    for (int k = 0; k < int'(D); k++)
                        if (hist[i][(n - k) % HL] == lvl[i]) all_diff = 0;
                    if (all_diff != 0) begin
                        lvl[i] = 1 - lvl[i];
                        rose = lvl[i];
                        start[i] = n + 1;
                    end
                end
                rose_last[i] = rose;
                m2[i] = m1[i];
                m1[i] = raw[i];
            end
        end
        e.value = m_val;
        e.wrap = w;
        e.clamped = c;
        sb.push_back(e);
    endfunction

    // One clock: model sees the inputs sampled at this edge; inputs may change afterwards.
    task automatic cyc();
        @(posedge clk);
        model_edge(int'(reset), int'(bus.key_up), int'(bus.key_down),
                   int'(bus.load), int'(bus.load_val));
        #2;
    endtask

    task automatic do_load(input int v);
        bus.load = 1'b1;
        bus.load_val = 5'(v);
        cyc();
        bus.load = 1'b0;
    endtask

    // Monitor: every edge produces an output word; compare it 1 time unit later.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("value", int'(bus.value), e.value);
                check("wrap", int'(bus.wrap), e.wrap);
                check("clamped", int'(bus.clamped), e.clamped);
            end
        end
    end

    initial begin
        reset = 1'b1;
        bus.key_up = 1'b0;
        bus.key_down = 1'b0;
        bus.load = 1'b0;
        bus.load_val = '0;

        // Reset, then a single held press.
        repeat (2) cyc();
        reset = 1'b0;
        check("reset_value", int'(bus.value), 0);
        check("reset_wrap", int'(bus.wrap), 0);
        check("reset_clamped", int'(bus.clamped), 0);
        bus.key_up = 1'b1;
        repeat (7) cyc();
        check("before_step", int'(bus.value), 0);
        cyc();
        check("single_press", int'(bus.value), 1);
        repeat (50) cyc();
        check("hold_no_repeat", int'(bus.value), 1);
        bus.key_up = 1'b0;
        repeat (8) cyc();

        // Bounce rejection.
        do_load(7);
        for (int i = 0; i < 10; i++) begin
            bus.key_down = 1'b1;
            repeat (3) cyc();
            bus.key_down = 1'b0;
            cyc();
        end
        repeat (10) cyc();
        check("bounce_rejected", int'(bus.value), 7);

        // Wrap up then down.
        do_load(19);
        bus.key_up = 1'b1;
        repeat (8) cyc();
        check("wrap_up_value", int'(bus.value), 0);
        check("wrap_up_pulse", int'(bus.wrap), 1);
        cyc();
        check("wrap_up_single", int'(bus.wrap), 0);
        bus.key_up = 1'b0;
        repeat (8) cyc();
        bus.key_down = 1'b1;
        repeat (8) cyc();
        check("wrap_dn_value", int'(bus.value), 19);
        check("wrap_dn_pulse", int'(bus.wrap), 1);
        cyc();
        check("wrap_dn_single", int'(bus.wrap), 0);
        bus.key_down = 1'b0;
        repeat (8) cyc();

        // Clamped load, then load coinciding with an up event.
        do_load(25);
        check("clamp_value", int'(bus.value), 19);
        check("clamp_pulse", int'(bus.clamped), 1);
        cyc();
        check("clamp_single", int'(bus.clamped), 0);
        bus.key_up = 1'b1;
        repeat (7) cyc();
        do_load(5);
        check("load_beats_event", int'(bus.value), 5);
        check("load_event_nowrap", int'(bus.wrap), 0);
        cyc();
        check("event_discarded", int'(bus.value), 5);
        bus.key_up = 1'b0;
        repeat (8) cyc();

        // Simultaneous presses cancel.
        do_load(10);
        bus.key_up = 1'b1;
        bus.key_down = 1'b1;
        repeat (12) cyc();
        check("both_keys_value", int'(bus.value), 10);
        bus.key_up = 1'b0;
        bus.key_down = 1'b0;
        repeat (8) cyc();
        check("both_keys_after", int'(bus.value), 10);

        // Reset one cycle before the expected step, key released with it.
        bus.key_up = 1'b1;
        repeat (6) cyc();
        reset = 1'b1;
        bus.key_up = 1'b0;
        cyc();
        reset = 1'b0;
        check("mid_reset_value", int'(bus.value), 0);
        repeat (12) cyc();
        check("no_step_after_reset", int'(bus.value), 0);

        // Randomized traffic: bouncy keys, sporadic loads and resets.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 5) == 0) bus.key_up = ~bus.key_up;
            if ($urandom_range(0, 5) == 0) bus.key_down = ~bus.key_down;
            bus.load = ($urandom_range(0, 11) == 0);
            bus.load_val = 5'($urandom_range(0, 31));
            reset = ($urandom_range(0, 399) == 0);
            cyc();
        end
        reset = 1'b0;
        bus.load = 1'b0;
        bus.key_up = 1'b0;
        bus.key_down = 1'b0;
        repeat (10) cyc();

        repeat (3) @(posedge clk);
        #2;
        check("scoreboard_drain", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
